// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO on a valid/ready handshake feeding
// an LSB-first serialiser; frames go out back-to-back while data is buffered.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES    = 234,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [7:0]                 data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic                       uart_tx_o,
  output logic                       busy_o,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = $clog2(DELAY_FRAMES + 1);
  localparam int NW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES);
  localparam logic [NW-1:0] FULL = NW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [2:0]                 idx_q, idx_d;
  logic [7:0]                 shift_q, shift_d;
  logic                       tx_q, tx_d;
  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]              count_q, count_d;
  logic                       push, pop, bit_end, have_data;

  assign ready_o      = (count_q != FULL);
  assign push         = valid_i && ready_o;
  assign have_data    = (count_q != '0);
  assign bit_end      = (cnt_q == LAST);
  assign uart_tx_o    = tx_q;
  assign busy_o       = (state_q != IDLE);
  assign fifo_count_o = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (have_data) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          cnt_d   = CW'(1);
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          cnt_d   = CW'(1);
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = CW'(1);
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = CW'(1);
          // Chain straight into the next start bit so frames have no idle gap.
          if (have_data) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + NW'(1);
    else if (pop && !push) count_d = count_q - NW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-plus-frame-timeline reference model checked
// every cycle, with directed scenarios around fill, back-to-back and reset.
module tb_uart_tx_fifo;

  localparam int D     = 4;
  localparam int DEPTH = 16;
  localparam int FL    = 10 * D;

  logic       clk = 1'b0;
  logic       reset_n, valid;
  logic [7:0] data;
  logic       ready, tx, busy;
  logic [4:0] cnt;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH_LOG2(4)) dut (
    .clk_i(clk), .reset_ni(reset_n), .data_i(data), .valid_i(valid),
    .ready_o(ready), .uart_tx_o(tx), .busy_o(busy), .fifo_count_o(cnt)
  );

  int compared = 0;
  int mism     = 0;

  // Model: buffered bytes in a queue, current frame as byte + clocks elapsed.
  logic [7:0] q[$];
  bit         active = 0;
  logic [7:0] cur;
  int         t = 0;
  bit         accepted;

  function automatic logic exp_line();
    int b;
    if (!active) return 1'b1;
    b = t / D;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int sz;
    bit push;
    @(posedge clk);
    accepted = 0;
    if (!reset_n) begin
      q.delete();
      active = 0;
      t = 0;
    end else begin
      sz   = q.size();
      push = valid && (sz < DEPTH);
      if ((!active || t == FL - 1) && sz != 0) begin
        cur = q.pop_front();
        active = 1;
        t = 0;
      end else if (active && t == FL - 1) begin
        active = 0;
      end else if (active) begin
        t++;
      end
      if (push) begin
        q.push_back(data);
        accepted = 1;
      end
    end
    #1;
    chk("tx", 32'(tx), 32'(exp_line()));
    chk("busy", 32'(busy), 32'(active));
    chk("count", 32'(cnt), 32'(q.size()));
    chk("ready", 32'(ready), 32'(q.size() < DEPTH));
  endtask

  initial begin
    logic [9:0] pat41;
    int busy_n, n_acc;
    logic [4:0] prev;
    bit seen;

    reset_n = 1'b0; valid = 1'b0; data = '0;
    tick(); tick();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // Single 0x41: start, 1,0,0,0,0,0,1,0 data, stop; falls one clock after push.
    pat41 = 10'b10_1000_0010;
    valid = 1'b1; data = 8'h41;
    tick();
    chk("push_edge_tx", 32'(tx), 32'd1);
    valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      tick();
      chk("frame41", 32'(tx), 32'(pat41[i / D]));
    end
    tick();
    chk("idle_after41", 32'(tx), 32'd1);

    // Back-to-back 0x55, 0xAA: busy for exactly two frames.
    busy_n = 0;
    valid = 1'b1; data = 8'h55;
    tick();
    data = 8'hAA;
    tick();
    if (busy) busy_n++;
    valid = 1'b0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (busy) busy_n++;
    end
    chk("busy80", 32'(busy_n), 32'(2 * FL));

    // Fill while the line is busy: 16 of 18 attempts accepted.
    valid = 1'b1; data = 8'($urandom);
    tick();
    valid = 1'b0;
    tick(); tick();
    n_acc = 0;
    valid = 1'b1; data = 8'($urandom);
    for (int i = 0; i < 18; i++) begin
      tick();
      if (accepted) begin
        n_acc++;
        data = 8'($urandom);
      end
    end
    chk("fill_acc", 32'(n_acc), 32'd16);
    chk("fill_cnt", 32'(cnt), 32'd16);
    chk("fill_ready", 32'(ready), 32'd0);

    // Pop edge with valid still high while full: no bypass, 16 -> 15.
    seen = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      prev = cnt;
      tick();
      if (prev == 5'd16 && cnt != 5'd16) begin
        chk("nobypass_cnt", 32'(cnt), 32'd15);
        chk("nobypass_acc", 32'(accepted), 32'd0);
        seen = 1;
        break;
      end
    end
    chk("pop_seen", 32'(seen), 32'd1);
    tick();
    chk("refill_cnt", 32'(cnt), 32'd16);
    valid = 1'b0;
    for (int i = 0; i < 18 * FL; i++) tick();
    chk("drain_cnt", 32'(cnt), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    // Reset during data bit 3 aborts the frame.
    valid = 1'b1; data = 8'($urandom);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    valid = 1'b1; data = 8'($urandom);
    tick();
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    reset_n = 1'b1; valid = 1'b0;
    tick();
    valid = 1'b1; data = 8'($urandom);
    tick();
    valid = 1'b0;
    for (int i = 0; i < FL + 5; i++) tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (accepted || !valid) begin
        valid = ($urandom_range(0, 3) == 0);
        data  = 8'($urandom);
      end
      tick();
    end
    valid = 1'b0;
    for (int i = 0; i < 17 * FL; i++) tick();
    chk("final_cnt", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
